// File: rtl/timer_multi.sv
// timer_multi: bank of NUM_CH independent count-up timers on the peripheral bus.
// Each channel has a prescaler, a compare register, one-shot or periodic mode,
// a write-1-to-clear pending flag and its own interrupt line. A global STATUS
// word exposes the pending vector so a handler can find the source in one read.
//
// Ports:
//   clk     - clock
//   rst     - synchronous, active-high reset
//   we_i    - single-cycle write strobe
//   addr_i  - word-aligned byte address
//   data_i  - write data
//   sel_i   - byte enables, sel_i[k] gates data_i[8k+7:8k]
//   data_o  - read data, combinational from addr_i
//   int_o   - per-channel interrupt (PEND & IE)
//   irq_o   - OR of all channel interrupts
module timer_multi #(
  parameter int          NUM_CH    = 3,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] int_o,
  output logic              irq_o
);

  logic [NUM_CH-1:0] en_q, en_d, ie_q, ie_d, pend_q, pend_d, mode_q, mode_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   count_q, count_d, cmp_q, cmp_d;
  logic [NUM_CH-1:0][PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;

  logic [31:0] blockOff;
  logic        chWindow;
  logic        isStatus;
  logic [3:0]  chSel;
  logic [1:0]  regSel;
  logic [31:0] wrMask;

  logic [NUM_CH-1:0] ctrlWr, countWr, cmpWr, prescWr, tick, expire;

  // Channel registers live in the first 256 bytes (16 bytes per channel);
  // misaligned addresses decode as unmapped.
  assign blockOff = addr_i - BASE_ADDR;
  assign isStatus = (blockOff == 32'h0000_0100);
  assign chWindow = (blockOff[31:8] == 24'd0) && (blockOff[1:0] == 2'b00);
  assign chSel    = blockOff[7:4];
  assign regSel   = blockOff[3:2];
  assign wrMask   = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  // Per-channel write decode, prescaler tick and expiry detection. A COUNT
  // write in the same cycle suppresses that cycle's expiry.
  always_comb begin
    ctrlWr  = '0;
    countWr = '0;
    cmpWr   = '0;
    prescWr = '0;
    tick    = '0;
    expire  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (we_i && chWindow && (chSel == 4'(n))) begin
        ctrlWr[n]  = (regSel == 2'd0) && sel_i[0];
        countWr[n] = (regSel == 2'd1);
        cmpWr[n]   = (regSel == 2'd2);
        prescWr[n] = (regSel == 2'd3);
      end
      tick[n]   = en_q[n] && (pcnt_q[n] == presc_q[n]);
      expire[n] = tick[n] && (count_q[n] >= cmp_q[n]) && !countWr[n];
    end
  end

  // Next-state logic: hardware counting first, then software writes layered
  // on top so that a write wins wherever both touch the same field.
  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    for (int n = 0; n < NUM_CH; n++) begin
      pcnt_d[n] = tick[n] ? '0 : pcnt_q[n] + PRESC_W'(1);

      if (tick[n] && !countWr[n]) begin
        if (expire[n]) begin
          count_d[n] = '0;
          pend_d[n]  = 1'b1;
          if (!mode_q[n]) begin
            en_d[n] = 1'b0;
          end
        end else begin
          count_d[n] = count_q[n] + CNT_W'(1);
        end
      end

      // A hardware expiry in the same cycle keeps PEND set despite W1C.
      if (ctrlWr[n]) begin
        en_d[n]   = data_i[0];
        ie_d[n]   = data_i[1];
        mode_d[n] = data_i[3];
        pend_d[n] = expire[n] | (pend_q[n] & ~data_i[2]);
        if (data_i[0] && !en_q[n]) begin
          pcnt_d[n] = '0;
        end
      end

      if (countWr[n]) begin
        count_d[n] = (count_q[n] & ~wrMask[CNT_W-1:0]) | (data_i[CNT_W-1:0] & wrMask[CNT_W-1:0]);
        pcnt_d[n]  = '0;
      end
      if (cmpWr[n]) begin
        cmp_d[n] = (cmp_q[n] & ~wrMask[CNT_W-1:0]) | (data_i[CNT_W-1:0] & wrMask[CNT_W-1:0]);
      end
      if (prescWr[n]) begin
        presc_d[n] = (presc_q[n] & ~wrMask[PRESC_W-1:0]) | (data_i[PRESC_W-1:0] & wrMask[PRESC_W-1:0]);
      end

      // The prescaler is parked at zero whenever the channel is disabled.
      if (!en_d[n]) begin
        pcnt_d[n] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      ie_q    <= '0;
      pend_q  <= '0;
      mode_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Read mux; anything that does not decode returns zero.
  always_comb begin
    data_o = '0;
    if (isStatus) begin
      data_o[NUM_CH-1:0] = pend_q;
    end else if (chWindow) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (chSel == 4'(n)) begin
          case (regSel)
            2'd0:    data_o[3:0]         = {mode_q[n], pend_q[n], ie_q[n], en_q[n]};
            2'd1:    data_o[CNT_W-1:0]   = count_q[n];
            2'd2:    data_o[CNT_W-1:0]   = cmp_q[n];
            default: data_o[PRESC_W-1:0] = presc_q[n];
          endcase
        end
      end
    end
  end

  assign int_o = pend_q & ie_q;
  assign irq_o = |int_o;

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised count-up timer bank with NUM_CH independent channels on the core's memory-mapped peripheral bus.
- Each channel provides a per-channel prescaler, a compare register, one-shot or periodic mode, a write-1-to-clear pending flag and its own interrupt line.
- A global status register lets the interrupt handler find the pending channel with a single read.

Parameters:
- NUM_CH, 3, number of timer channels (1..8).
- CNT_W, 32, counter and compare width in bits (8..32).
- PRESC_W, 16, prescaler width in bits (1..16).
- BASE_ADDR, 32'h20000, bus base address; the block decodes BASE_ADDR..BASE_ADDR+0x103.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- we_i  input  1  write strobe, valid for one cycle.
- addr_i  input  32  byte address, word aligned.
- data_i  input  32  write data.
- sel_i  input  4  byte enables; sel_i[k] gates data_i[8k+7:8k].
- data_o  output  32  read data, combinational from addr_i.
- int_o  output  NUM_CH  per-channel interrupt, bit n = PEND[n] & IE[n].
- irq_o  output  1  OR of int_o.

Behaviour:
- Register map. Channel n base is BASE_ADDR + n*0x10.
  - +0x0 CTRL: [0] EN; [1] IE; [2] PEND, read 1 / write-1-to-clear; [3] MODE, 0 = one-shot, 1 = periodic. Bits [31:4] read 0.
  - +0x4 COUNT: read/write, CNT_W bits, zero-extended on read.
  - +0x8 CMP: read/write, CNT_W bits.
  - +0xC PRESC: read/write, PRESC_W bits. The channel ticks every PRESC+1 clocks.
  - BASE_ADDR+0x100 STATUS: read-only, bits [NUM_CH-1:0] = PEND vector. Writes ignored.
- Reads: unmapped offsets, channels >= NUM_CH, and addresses outside the block all return 0. Writes to those addresses have no effect.
- Byte-select writes:
  - Only enabled bytes update the register.
  - Bits above CNT_W / PRESC_W are dropped.
  - PEND clears only if sel_i[0]=1 and data_i[2]=1.
- Reset: all CTRL, COUNT, CMP, PRESC and internal prescaler counters go to 0. int_o=0, irq_o=0.
- Prescaler:
  - Internal pcnt[n] is held at 0 while EN=0.
  - While EN=1: if pcnt==PRESC, tick=1 and pcnt<=0; otherwise pcnt<=pcnt+1.
  - PRESC=0 gives a tick every clock.
- Counting, on tick with EN=1:
  - If COUNT >= CMP (expiry): PEND<=1 and COUNT<=0. If MODE=0, also EN<=0.
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^CNT_W.
- EN=0: COUNT holds its value and is not cleared. Software may preload it.
- Expiry latency:
  - From the EN write cycle with COUNT=0, PEND rises (CMP+1)*(PRESC+1) clocks after the write.
  - int_o follows PEND combinationally.
- Simultaneous events in the same cycle:
  - Hardware PEND set beats a software W1C, so PEND stays 1.
  - A software COUNT write beats increment and expiry reload; the expiry of that cycle is suppressed, and pcnt<=0.
  - A software CTRL write with EN=1 beats the one-shot auto-clear of EN.
  - A software write EN 0->1 resets pcnt to 0.
- CMP=0: expiry on every tick.
- Lowering CMP below the current COUNT causes expiry on the next tick. The comparison is >=.
- Channels are fully independent. A write touches at most one register.
- Reset asserted mid-count overrides everything on that edge.

Test Plan:
- Reset, then read every register of channels 0..2 and STATUS -> all read 0, int_o=0, irq_o=0.
- Ch0: PRESC=0, CMP=4, write CTRL=0x3 (EN, IE, one-shot) -> PEND and int_o[0] rise on the 5th clock after the write; COUNT=0 and EN=0 afterwards; COUNT stays 0.
- Ch1: PRESC=3, CMP=2, CTRL=0xB (periodic) -> PEND sets at clock 12. EN stays 1 and a second expiry arrives at clock 24. Write CTRL=0xF (W1C) -> PEND=0, EN, IE and MODE unchanged, int_o[1] drops the next cycle.
- W1C on the same cycle as an expiry -> PEND reads 1. A COUNT write of 0x10 on an expiry cycle -> COUNT reads 0x10 and no new PEND.
- Byte writes: CMP=0xFFFFFFFF, then write data 0x00001200 with sel=0010 -> CMP reads 0xFFFF12FF. With CNT_W=8, write 0x1234 to COUNT -> reads 0x34.
- Ch0 and ch2 expire in the same cycle -> STATUS=0x5, irq_o=1. Clear ch0 only -> STATUS=0x4, irq_o stays 1. A read at offset 0x30 or 0x104 returns 0.
